delayed_axi_sram: RTL

DELAYED_AXI_SRAM -- requirements
Module: delayed_axi_sram

---
 rtl/delayed_axi_sram_pkg.sv | 47 ++++
 rtl/delayed_axi_sram_if.sv | 48 ++++
 rtl/sram_byte_array.sv | 43 ++++
 rtl/delayed_axi_sram.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/delayed_axi_sram_pkg.sv
`default_nettype none
// ============================================================================
// Module      : delayed_axi_sram_pkg
// Description : Shared types for the delayed AXI-lite SRAM. Holds the read and
//               write FSM state encodings, the response codes and the
//               address-decode helper.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package delayed_axi_sram_pkg;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic        hit;   // address falls inside the array window
    logic [29:0] word;  // word offset from the base (valid when hit)
  } addr_dec_t;

  // Byte address -> (hit, word index). The range test is done on the word
  // offset so that BASE + 4*DEPTH near the top of the address map cannot
  // overflow. addr[1:0] never affects the result.
  function automatic addr_dec_t addr_decode(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] depth);
    addr_dec_t   d;
    logic [31:0] off;
    off    = addr - base;
    d.word = off[31:2];
    d.hit  = (addr >= base) && ({2'b00, off[31:2]} < depth);
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delayed_axi_sram_if.sv
`default_nettype none
// ============================================================================
// Module      : delayed_axi_sram_if
// Description : AXI-lite style read/write channels plus the delay-generator
//               grant pulse for delayed_axi_sram.
// Ports       : slave  - used by the SRAM (drives ready/valid responses)
//               master - used by the requester / testbench
// Revision    : 1.0 - initial release
// ============================================================================
interface delayed_axi_sram_if;
  logic        delay_trigger;
  // read address / data
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  // write address / data / response
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  delay_trigger,
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid,
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output delay_trigger,
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid,
    output awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
endinterface
`default_nettype wire

// File: rtl/sram_byte_array.sv
`default_nettype none
// ============================================================================
// Module      : sram_byte_array
// Description : DEPTH x 32 storage, byte-masked synchronous write port and a
//               combinational read port. Contents are deliberately not reset.
// Ports       : clk_i     - clock
//               we_i      - write enable (commit on rising edge)
//               waddr_i   - write word index
//               wdata_i   - write data
//               wstrb_i   - byte enables, bit b covers wdata_i[8b+7:8b]
//               raddr_i   - read word index
//               rdata_o   - read data (old value in a same-cycle write)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_byte_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  wire logic          clk_i,
  input  wire logic          we_i,
  input  wire logic [AW-1:0] waddr_i,
  input  wire logic [31:0]   wdata_i,
  input  wire logic [3:0]    wstrb_i,
  input  wire logic [AW-1:0] raddr_i,
  output logic      [31:0]   rdata_o
);

  logic [3:0][7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb_i[b]) begin
          mem_q[waddr_i][b] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/delayed_axi_sram.sv
`default_nettype none
// ============================================================================
// Module      : delayed_axi_sram
// Description : AXI-lite SRAM whose accesses complete only when the upstream
//               delay generator grants a trigger cycle. Independent read and
//               write FSMs; one trigger may complete both.
// Ports       : clk - clock, rising edge
//               rst - synchronous, active-low reset
//               bus - delayed_axi_sram_if.slave (AR/R/AW/W/B + delay_trigger)
// Revision    : 1.0 - initial release
// ============================================================================
module delayed_axi_sram
  import delayed_axi_sram_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h8000_0000
) (
  input  wire logic            clk,
  input  wire logic            rst,
  delayed_axi_sram_if.slave    bus
);

  localparam int unsigned AW = $clog2(DEPTH);

  // --------------------------------------------------------------------------
  // Read channel
  // --------------------------------------------------------------------------
  rd_state_e   rd_state_q, rd_state_d;
  logic [31:0] ar_addr_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  addr_dec_t   rd_dec;
  logic [31:0] mem_rdata;

  assign rd_dec = addr_decode(ar_addr_q, BASE, 32'(DEPTH));

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_state_q <= R_IDLE;
    end else begin
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (bus.arvalid)       rd_state_d = R_WAIT;
      R_WAIT:  if (bus.delay_trigger) rd_state_d = R_RESP;
      R_RESP:  if (bus.rready)        rd_state_d = R_IDLE;
      default:                        rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    bus.arready = (rd_state_q == R_IDLE);
    bus.rvalid  = (rd_state_q == R_RESP);
  end

  // Address latch needs no reset: it is only consumed after a capture.
  always_ff @(posedge clk) begin
    if (rd_state_q == R_IDLE && bus.arvalid) begin
      ar_addr_q <= bus.araddr;
    end
  end

  // Response is sampled once on the WAIT->RESP edge and held until accepted.
  // The array read port is combinational, so a write committing on the same
  // edge is not yet visible here and the pre-write value is returned.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (rd_state_q == R_WAIT && bus.delay_trigger) begin
      rdata_q <= rd_dec.hit ? mem_rdata : 32'h0;
      rresp_q <= rd_dec.hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.rresp = rresp_q;

  // --------------------------------------------------------------------------
  // Write channel
  // --------------------------------------------------------------------------
  wr_state_e   wr_state_q, wr_state_d;
  logic        aw_got_q, aw_got_d;
  logic        w_got_q, w_got_d;
  logic [31:0] aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  bresp_q;
  logic        aw_fire, w_fire, aw_have, w_have;
  logic        mem_we;
  addr_dec_t   wr_dec;

  assign wr_dec  = addr_decode(aw_addr_q, BASE, 32'(DEPTH));

  assign aw_fire = (wr_state_q == W_IDLE) && !aw_got_q && bus.awvalid;
  assign w_fire  = (wr_state_q == W_IDLE) && !w_got_q  && bus.wvalid;
  assign aw_have = aw_got_q | aw_fire;
  assign w_have  = w_got_q  | w_fire;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_state_q <= W_IDLE;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_d;
      aw_got_q   <= aw_got_d;
      w_got_q    <= w_got_d;
    end
  end

  always_comb begin
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE:  if (aw_have && w_have) wr_state_d = W_WAIT;
      W_WAIT:  if (bus.delay_trigger) wr_state_d = W_RESP;
      W_RESP:  if (bus.bready)        wr_state_d = W_IDLE;
      default:                        wr_state_d = W_IDLE;
    endcase
  end

  // Per-channel "already captured" flags only live while idle; they clear as
  // soon as both halves are in hand so the next transaction starts fresh.
  always_comb begin
    aw_got_d = 1'b0;
    w_got_d  = 1'b0;
    if (wr_state_q == W_IDLE && !(aw_have && w_have)) begin
      aw_got_d = aw_have;
      w_got_d  = w_have;
    end
  end

  always_comb begin
    bus.awready = (wr_state_q == W_IDLE) && !aw_got_q;
    bus.wready  = (wr_state_q == W_IDLE) && !w_got_q;
    bus.bvalid  = (wr_state_q == W_RESP);
  end

  always_ff @(posedge clk) begin
    if (aw_fire) begin
      aw_addr_q <= bus.awaddr;
    end
    if (w_fire) begin
      w_data_q <= bus.wdata;
      w_strb_q <= bus.wstrb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      bresp_q <= RESP_OKAY;
    end else if (wr_state_q == W_WAIT && bus.delay_trigger) begin
      bresp_q <= wr_dec.hit ? RESP_OKAY : RESP_DECERR;
    end
  end

  assign bus.bresp = bresp_q;

  // Gated by rst so a reset arriving together with a trigger never commits.
  assign mem_we = rst && (wr_state_q == W_WAIT) && bus.delay_trigger && wr_dec.hit;

  // Upper word-offset bits are out of range whenever they matter, which the
  // hit flag already covers; they are intentionally dropped from the index.
  logic w_unused_word_bits;
  assign w_unused_word_bits = ^{rd_dec.word[29:AW], wr_dec.word[29:AW]};

  // --------------------------------------------------------------------------
  // Storage
  // --------------------------------------------------------------------------
  sram_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (wr_dec.word[AW-1:0]),
    .wdata_i (w_data_q),
    .wstrb_i (w_strb_q),
    .raddr_i (rd_dec.word[AW-1:0]),
    .rdata_o (mem_rdata)
  );

endmodule
`default_nettype wire
